// File: rtl/serial_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_port                                                |
// | Description : Byte-level UART responder for the processor serial strobes.|
// |               TX shifts bytes out on tx_out; RX deserialises rx_in into  |
// |               a show-ahead FIFO drained by rden_in.                      |
// |               Optional even parity: define SERIAL_PORT_PARITY_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_data_in,
  input  logic       wren_in,
  input  logic       rden_in,
  output logic [7:0] rd_data_out,
  output logic       valid_out,
  output logic       ready_out,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       overrun_out,
  output logic       frame_err_out
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_ptr_w = $clog2(RX_DEPTH);

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]   c_count_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w + 1)'(RX_DEPTH);

`ifdef SERIAL_PORT_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  // ---------------------------------------------------------------- TX
  state_e              tx_state_q, tx_state_d;
  logic [c_cnt_w-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic                tx_q, tx_d;
  logic                tx_bit_done;
`ifdef SERIAL_PORT_PARITY_EN
  logic                tx_par_q, tx_par_d;
`endif

  assign tx_bit_done = (tx_cnt_q == c_bit_last);

  // TX next-state: each line bit is held for CLKS_PER_BIT cycles, LSB first.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
`ifdef SERIAL_PORT_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q == S_IDLE) begin
      tx_d     = 1'b1;
      tx_cnt_d = '0;
      if (wren_in) begin
        tx_state_d = S_START;
        tx_d       = 1'b0;
        tx_shift_d = wr_data_in;
`ifdef SERIAL_PORT_PARITY_EN
        tx_par_d   = ^wr_data_in;
`endif
      end
    end else if (!tx_bit_done) begin
      tx_cnt_d = tx_cnt_q + c_cnt_one;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end
        S_DATA: begin
          if (tx_bit_q == 3'd7) begin
`ifdef SERIAL_PORT_PARITY_EN
            tx_state_d = S_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
`ifdef SERIAL_PORT_PARITY_EN
        S_PARITY: begin
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end
`endif
        default: begin
          tx_state_d = S_IDLE;
          tx_d       = 1'b1;
        end
      endcase
    end
  end

  // TX state register; line idles high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef SERIAL_PORT_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef SERIAL_PORT_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx_out    = tx_q;
  assign ready_out = (tx_state_q == S_IDLE);

  // ---------------------------------------------------------------- RX
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  state_e              rx_state_q, rx_state_d;
  logic [c_cnt_w-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                rx_push, rx_ferr;
  logic                rx_par_ok;
`ifdef SERIAL_PORT_PARITY_EN
  logic                rx_par_q, rx_par_d;
  assign rx_par_ok = ((^rx_shift_q) == rx_par_q);
`else
  assign rx_par_ok = 1'b1;
`endif

  // RX next-state: start sampled at half a bit, then every full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + c_cnt_one;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
`ifdef SERIAL_PORT_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == c_half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef SERIAL_PORT_PARITY_EN
            rx_state_d = S_PARITY;
`else
            rx_state_d = S_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef SERIAL_PORT_PARITY_EN
      S_PARITY: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = S_STOP;
        end
      end
`endif
      default: begin
        if (rx_cnt_q == c_bit_last) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_sync_q && rx_par_ok) rx_push = 1'b1;
          else                        rx_ferr = 1'b1;
        end
      end
    endcase
  end

  // RX synchronizer and state register; sync flops reset to line-idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
`ifdef SERIAL_PORT_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
`ifdef SERIAL_PORT_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]          mem_q [RX_DEPTH];
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]    count_q, count_d;
  logic [7:0]          head_q, head_d;
  logic                overrun_q, frame_err_q;
  logic                pop, push_ok;

  assign pop     = rden_in && (count_q != '0);
  assign push_ok = rx_push && ((count_q != c_depth) || pop);

  // FIFO bookkeeping; the head register tracks the entry that will be at the front.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + c_ptr_one : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + c_ptr_one : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + c_count_one;
    else if (!push_ok && pop) count_d = count_q - c_count_one;
    head_d = head_q;
    if (count_d != '0) begin
      if (push_ok && ((count_q == '0) || (pop && (count_q == c_count_one))))
        head_d = rx_shift_q;
      else
        head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO control, head register and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (rx_push && !push_ok) overrun_q   <= 1'b1;
      if (rx_ferr)             frame_err_q <= 1'b1;
    end
  end

  // FIFO storage; contents are only read while the count says they are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign rd_data_out   = head_q;
  assign valid_out     = (count_q != '0);
  assign overrun_out   = overrun_q;
  assign frame_err_out = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_port                                             |
// | Description : Directed self-checking bench for serial_port (CPB=4,       |
// |               depth 4). Honours SERIAL_PORT_PARITY_EN when defined.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_PORT_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wren, rden, rx_in;
  logic [7:0] rd_data;
  logic       valid, ready, tx, overrun, ferr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .wr_data_in   (wr_data),
    .wren_in      (wren),
    .rden_in      (rden),
    .rd_data_out  (rd_data),
    .valid_out    (valid),
    .ready_out    (ready),
    .rx_in        (rx_in),
    .tx_out       (tx),
    .overrun_out  (overrun),
    .frame_err_out(ferr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one complete frame on rx_in (correct parity when enabled).
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
`ifdef SERIAL_PORT_PARITY_EN
    rx_in = ^b;
    tick(CPB);
`endif
    rx_in = stop_bit;
    tick(CPB);
    rx_in = 1'b1;
  endtask

`ifdef SERIAL_PORT_PARITY_EN
  task automatic send_rx_badpar(input logic [7:0] b);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = ~(^b);
    tick(CPB);
    rx_in = 1'b1;
    tick(CPB);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] frame;
    int          bad;

    rst_n = 1'b0; wr_data = 8'h00; wren = 1'b0; rden = 1'b0; rx_in = 1'b1;
    tick(3);
    check("rst_tx",      tx,      1);
    check("rst_ready",   ready,   1);
    check("rst_valid",   valid,   0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ferr",    ferr,    0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      tick(1);
      if (tx !== 1'b1 || ready !== 1'b1 || valid !== 1'b0 || overrun !== 1'b0 || ferr !== 1'b0)
        bad++;
    end
    check("idle_100", bad, 0);

    // TX 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
    frame = '1;
    frame[0] = 1'b0;
    frame[8:1] = 8'hA5;
`ifdef SERIAL_PORT_PARITY_EN
    frame[9] = 1'b0;
`endif
    wr_data = 8'hA5; wren = 1'b1;
    tick(1);
    wren = 1'b0;
    for (int k = 0; k < NBITS * CPB; k++) begin
      check($sformatf("tx_bit%0d", k / CPB), tx, frame[k / CPB]);
      check("tx_ready_low", ready, 0);
      if (k == 12) begin
        wr_data = 8'h00; wren = 1'b1;
      end else begin
        wren = 1'b0;
      end
      tick(1);
    end
    check("tx_ready_back", ready, 1);
    check("tx_idle_high",  tx,    1);
    tick(3 * CPB);
    check("tx_ignored_wr_ready", ready, 1);
    check("tx_ignored_wr_line",  tx,    1);

    // RX 0x3C then single pop
    send_rx(8'h3C, 1'b1);
    tick(4);
    check("rx_valid",   valid,   1);
    check("rx_data",    rd_data, 8'h3C);
    check("rx_ferr",    ferr,    0);
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
    check("pop_valid",  valid,   0);
    check("pop_hold",   rd_data, 8'h3C);
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
    check("pop_empty_ignored", valid, 0);

    // Five back-to-back frames into a 4-deep FIFO
    for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
    tick(6);
    check("ovr_flag",  overrun, 1);
    check("ovr_valid", valid,   1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_pop%0d", i), rd_data, i + 1);
      rden = 1'b1;
      tick(1);
      rden = 1'b0;
    end
    check("ovr_drained", valid, 0);

    // Short glitch: false start
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(20);
    check("glitch_valid", valid, 0);
    check("glitch_ferr",  ferr,  0);

    // Stop bit forced low
    send_rx(8'h55, 1'b0);
    tick(8);
    check("badstop_valid",   valid,   0);
    check("badstop_ferr",    ferr,    1);
    check("overrun_sticky",  overrun, 1);

    // Reset in the middle of TX and RX frames
    send_rx(8'h81, 1'b1);
    tick(4);
    check("pre_rst_valid", valid, 1);
    wr_data = 8'h12; wren = 1'b1;
    tick(1);
    wren = 1'b0;
    rx_in = 1'b0;
    tick(CPB);
    rx_in = 1'b1;
    tick(2 * CPB);
    check("mid_tx_busy", ready, 0);
    rst_n = 1'b0; rx_in = 1'b1;
    tick(1);
    rst_n = 1'b1;
    check("mrst_tx",      tx,      1);
    check("mrst_ready",   ready,   1);
    check("mrst_valid",   valid,   0);
    check("mrst_rd_data", rd_data, 0);
    check("mrst_ferr",    ferr,    0);
    check("mrst_overrun", overrun, 0);
    tick(60);
    check("mrst_no_push", valid, 0);
    check("mrst_no_ferr", ferr,  0);
    check("mrst_tx_idle", tx,    1);

`ifdef SERIAL_PORT_PARITY_EN
    send_rx_badpar(8'h07);
    tick(8);
    check("badpar_valid", valid, 0);
    check("badpar_ferr",  ferr,  1);
    send_rx(8'h07, 1'b1);
    tick(8);
    check("goodpar_valid", valid,   1);
    check("goodpar_data",  rd_data, 8'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
